// File: rtl/noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : noc_traffic_gen
// Purpose  : AXI-Stream packet generator for NoC bring-up and soak testing.
//            Define TRAFFIC_GEN_LFSR_PAYLOAD_EN for an LFSR in tdata[W-1:32].
// Revision : 1.0 - initial release
// ============================================================================
module noc_traffic_gen #(
   parameter int TDATA_WIDTH       = 64,
   parameter int TDEST_WIDTH       = 4,
   parameter int TID_WIDTH         = 2,
   parameter int NOC_NUM_ENDPOINTS = 9,
   parameter int MAX_PKT_LEN       = 16,
   parameter int LEN_WIDTH         = $clog2(MAX_PKT_LEN + 1)
) (
   input  logic                   clk_usr,
   input  logic                   rst_n,
   input  logic                   cfg_start,
   input  logic                   cfg_stop,
   input  logic [15:0]            cfg_num_pkts,
   input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
   input  logic [7:0]             cfg_gap,
   input  logic                   cfg_dest_mode,
   input  logic [TDEST_WIDTH-1:0] cfg_fixed_dest,
   input  logic [TID_WIDTH-1:0]   cfg_tid,
   input  logic [TDEST_WIDTH-1:0] self_addr,
   output logic                   axis_out_tvalid,
   input  logic                   axis_out_tready,
   output logic [TDATA_WIDTH-1:0] axis_out_tdata,
   output logic                   axis_out_tlast,
   output logic [TID_WIDTH-1:0]   axis_out_tid,
   output logic [TDEST_WIDTH-1:0] axis_out_tdest,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            pkts_sent,
   output logic [31:0]            flits_sent
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;

   localparam logic [TDEST_WIDTH-1:0] c_rr_last  = TDEST_WIDTH'(NOC_NUM_ENDPOINTS - 1);
   localparam logic [TDEST_WIDTH-1:0] c_dest_one = TDEST_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]   c_len_max  = LEN_WIDTH'(MAX_PKT_LEN);
   localparam logic [LEN_WIDTH-1:0]   c_len_one  = LEN_WIDTH'(1);
   localparam int                     c_hi_w     = (TDATA_WIDTH > 32) ? TDATA_WIDTH - 32 : 1;

   state_t                 r_state, w_state_nxt;
   logic [LEN_WIDTH-1:0]   r_len, w_len_nxt, r_idx, w_idx_nxt;
   logic [15:0]            r_num, w_num_nxt, r_seq, w_seq_nxt, r_pkts, w_pkts_nxt;
   logic [31:0]            r_flits, w_flits_nxt, w_lo_nxt;
   logic [7:0]             r_gap, w_gap_nxt, r_gcnt, w_gcnt_nxt;
   logic                   r_mode, w_mode_nxt, r_done, w_done_nxt, r_stop, w_stop_nxt;
   logic [TDEST_WIDTH-1:0] r_fixed, w_fixed_nxt, r_self, w_self_nxt;
   logic [TDEST_WIDTH-1:0] r_ptr, w_ptr_nxt, w_dest_nxt, r_tdest;
   logic [TID_WIDTH-1:0]   r_tid, w_tid_nxt;
   logic [TDATA_WIDTH-1:0] r_tdata, w_tdata_nxt;
   logic [c_hi_w-1:0]      w_hi_nxt;
   logic                   r_tvalid, r_tlast, r_busy;
   logic                   w_start, w_hs, w_tail, w_run_done;

   function automatic logic [TDEST_WIDTH-1:0] f_rr_step(input logic [TDEST_WIDTH-1:0] p);
      return (p == c_rr_last) ? '0 : p + c_dest_one;
   endfunction

   function automatic logic [TDEST_WIDTH-1:0] f_rr_skip(input logic [TDEST_WIDTH-1:0] p,
                                                        input logic [TDEST_WIDTH-1:0] s);
      return (p == s) ? f_rr_step(p) : p;
   endfunction

   function automatic logic [LEN_WIDTH-1:0] f_clamp(input logic [LEN_WIDTH-1:0] l);
      if (l == '0) return c_len_one;
      if (l > c_len_max) return c_len_max;
      return l;
   endfunction

   assign w_start    = (r_state == ST_IDLE) & cfg_start;
   assign w_hs       = r_tvalid & axis_out_tready;
   assign w_tail     = w_hs & r_tlast;
   assign w_run_done = (r_num != 16'd0) && (r_pkts + 16'd1 == r_num);

   always_ff @(posedge clk_usr) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (cfg_start) w_state_nxt = ST_SEND;
         ST_SEND: begin
            if (w_tail) begin
               if (w_run_done || r_stop || cfg_stop) w_state_nxt = ST_IDLE;
               else if (r_gap != 8'd0)               w_state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cfg_stop)                      w_state_nxt = ST_IDLE;
            else if (r_gcnt == r_gap - 8'd1)   w_state_nxt = ST_SEND;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Next-cycle datapath; output flops load from these so the bus is fully registered.
   always_comb begin
      w_len_nxt   = r_len;
      w_num_nxt   = r_num;
      w_gap_nxt   = r_gap;
      w_mode_nxt  = r_mode;
      w_fixed_nxt = r_fixed;
      w_tid_nxt   = r_tid;
      w_self_nxt  = r_self;
      w_seq_nxt   = r_seq;
      w_idx_nxt   = r_idx;
      w_pkts_nxt  = r_pkts;
      w_flits_nxt = r_flits;
      w_ptr_nxt   = r_ptr;
      w_done_nxt  = r_done;
      w_stop_nxt  = r_stop;
      if (w_start) begin
         w_len_nxt   = f_clamp(cfg_pkt_len);
         w_num_nxt   = cfg_num_pkts;
         w_gap_nxt   = cfg_gap;
         w_mode_nxt  = cfg_dest_mode;
         w_fixed_nxt = cfg_fixed_dest;
         w_tid_nxt   = cfg_tid;
         w_self_nxt  = self_addr;
         w_seq_nxt   = '0;
         w_idx_nxt   = '0;
         w_pkts_nxt  = '0;
         w_flits_nxt = '0;
         w_ptr_nxt   = f_rr_skip('0, self_addr);
         w_done_nxt  = 1'b0;
         w_stop_nxt  = 1'b0;
      end else begin
         if (w_hs) begin
            w_flits_nxt = r_flits + 32'd1;
            w_idx_nxt   = r_idx + c_len_one;
         end
         if (w_tail) begin
            w_idx_nxt  = '0;
            w_seq_nxt  = r_seq + 16'd1;
            w_pkts_nxt = r_pkts + 16'd1;
            w_ptr_nxt  = f_rr_skip(f_rr_step(r_ptr), r_self);
         end
         if ((r_state == ST_SEND) && cfg_stop) w_stop_nxt = 1'b1;
         if ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE)) w_done_nxt = 1'b1;
      end
      w_gcnt_nxt = (r_state == ST_GAP) ? r_gcnt + 8'd1 : 8'd0;
      if (!w_mode_nxt)                 w_dest_nxt = w_fixed_nxt;
      else if (NOC_NUM_ENDPOINTS == 1) w_dest_nxt = w_self_nxt;
      else                             w_dest_nxt = w_ptr_nxt;
      w_lo_nxt = {8'(w_self_nxt), 8'(w_idx_nxt), w_seq_nxt};
   end

`ifdef TRAFFIC_GEN_LFSR_PAYLOAD_EN
   if (TDATA_WIDTH > 32) begin : g_lfsr
      localparam int c_rep = (c_hi_w + 31) / 32;
      logic [31:0]         r_lfsr, w_lfsr_nxt;
      logic [32*c_rep-1:0] w_rep;
      always_comb begin
         w_lfsr_nxt = r_lfsr;
         if (w_start)   w_lfsr_nxt = 32'hACE1_0001;
         else if (w_hs) w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h8020_0003) : (r_lfsr >> 1);
      end
      always_ff @(posedge clk_usr) begin
         if (!rst_n) r_lfsr <= '0;
         else        r_lfsr <= w_lfsr_nxt;
      end
      assign w_rep    = {c_rep{w_lfsr_nxt}};
      assign w_hi_nxt = w_rep[c_hi_w-1:0];
   end else begin : g_no_lfsr
      assign w_hi_nxt = '0;
   end
`else
   assign w_hi_nxt = '0;
`endif

   if (TDATA_WIDTH > 32) begin : g_tdata_wide
      assign w_tdata_nxt = {w_hi_nxt, w_lo_nxt};
   end else begin : g_tdata_narrow
      assign w_tdata_nxt = w_lo_nxt;
   end

   always_ff @(posedge clk_usr) begin
      if (!rst_n) begin
         r_len <= '0;  r_num <= '0;  r_gap <= '0;  r_mode <= 1'b0;
         r_fixed <= '0; r_tid <= '0; r_self <= '0; r_seq <= '0;
         r_idx <= '0;  r_pkts <= '0; r_flits <= '0; r_ptr <= '0;
         r_gcnt <= '0; r_done <= 1'b0; r_stop <= 1'b0;
         r_tvalid <= 1'b0; r_tlast <= 1'b0; r_tdest <= '0; r_tdata <= '0; r_busy <= 1'b0;
      end else begin
         r_len <= w_len_nxt;   r_num <= w_num_nxt;   r_gap <= w_gap_nxt;   r_mode <= w_mode_nxt;
         r_fixed <= w_fixed_nxt; r_tid <= w_tid_nxt; r_self <= w_self_nxt; r_seq <= w_seq_nxt;
         r_idx <= w_idx_nxt;   r_pkts <= w_pkts_nxt; r_flits <= w_flits_nxt; r_ptr <= w_ptr_nxt;
         r_gcnt <= w_gcnt_nxt; r_done <= w_done_nxt; r_stop <= w_stop_nxt;
         r_tvalid <= (w_state_nxt == ST_SEND);
         r_tlast  <= (w_idx_nxt == w_len_nxt - c_len_one);
         r_tdest  <= w_dest_nxt;
         r_tdata  <= w_tdata_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
      end
   end

   assign axis_out_tvalid = r_tvalid;
   assign axis_out_tdata  = r_tdata;
   assign axis_out_tlast  = r_tlast;
   assign axis_out_tid    = r_tid;
   assign axis_out_tdest  = r_tdest;
   assign busy            = r_busy;
   assign done            = r_done;
   assign pkts_sent       = r_pkts;
   assign flits_sent      = r_flits;

endmodule
`default_nettype wire
